uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver: the receive end of the 8N1 link driven by UART_transmitter.

---
 rtl/uart_receiver.sv | 151 +++++++++++++++
 tb/tb_uart_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled RxD, start/stop validation, held output byte
// with receive-full, framing-error and overrun flags cleared by a host read pulse.
module uart_receiver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RxD,
  input  logic       UART_rd,
  output logic [7:0] dout,
  output logic       RF,
  output logic       FE,
  output logic       OE
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [1:0]       r_sync;
  logic [DIV_W-1:0] r_div;
  logic             r_prev;
  state_t           r_state;
  logic [3:0]       r_scnt;
  logic [2:0]       r_bcnt;
  logic [7:0]       r_sr;
  logic [7:0]       r_dout;
  logic             r_rf;
  logic             r_fe;
  logic             r_oe;

  state_t           w_state_nxt;
  logic [3:0]       w_scnt_nxt;
  logic [2:0]       w_bcnt_nxt;
  logic [7:0]       w_sr_nxt;
  logic             w_byte_good;
  logic             w_frame_err;
  logic             w_rxs;
  logic             w_tick;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_div == DIV_W'(DIV - 1));

  // r_prev holds the line as seen on the previous tick so IDLE reacts to a fall, not a level.
  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= 2'b11;
      r_div  <= '0;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], RxD};
      if (w_tick) begin
        r_div  <= '0;
        r_prev <= w_rxs;
      end else begin
        r_div  <= r_div + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise idle paths infer latches.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bcnt_nxt  = r_bcnt;
    w_sr_nxt    = r_sr;
    w_byte_good = 1'b0;
    w_frame_err = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxs && r_prev) begin
            w_state_nxt = S_START;
            w_scnt_nxt  = 4'd0;
          end
        end
        S_START: begin
          if (r_scnt == 4'd7) begin
            w_scnt_nxt  = 4'd0;
            w_bcnt_nxt  = 3'd0;
            w_state_nxt = w_rxs ? S_IDLE : S_DATA;
          end else begin
            w_scnt_nxt = r_scnt + 4'd1;
          end
        end
        S_DATA: begin
          w_scnt_nxt = r_scnt + 4'd1;
          if (r_scnt == 4'd15) begin
            w_sr_nxt = {w_rxs, r_sr[7:1]};
            if (r_bcnt == 3'd7) w_state_nxt = S_STOP;
            else                w_bcnt_nxt  = r_bcnt + 3'd1;
          end
        end
        S_STOP: begin
          w_scnt_nxt = r_scnt + 4'd1;
          if (r_scnt == 4'd15) begin
            w_byte_good = w_rxs;
            w_frame_err = !w_rxs;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_bcnt  <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_sr    <= w_sr_nxt;
    end
  end

  // A read in the byte-good cycle frees the slot, so the new byte lands instead of overrunning.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dout <= '0;
      r_rf   <= 1'b0;
      r_fe   <= 1'b0;
      r_oe   <= 1'b0;
    end else begin
      if (w_byte_good && (!r_rf || UART_rd)) r_dout <= r_sr;

      if (w_byte_good)  r_rf <= 1'b1;
      else if (UART_rd) r_rf <= 1'b0;

      if (w_frame_err)  r_fe <= 1'b1;
      else if (UART_rd) r_fe <= 1'b0;

      if (w_byte_good && r_rf && !UART_rd) r_oe <= 1'b1;
      else if (UART_rd)                    r_oe <= 1'b0;
    end
  end

  assign dout = r_dout;
  assign RF   = r_rf;
  assign FE   = r_fe;
  assign OE   = r_oe;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clk per bit: a frame-level model predicts each
// change of {dout,RF,FE,OE}; a negedge monitor compares every observed change in order.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       resetn;
  logic       RxD;
  logic       UART_rd;
  logic [7:0] dout;
  logic       RF;
  logic       FE;
  logic       OE;

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .RxD    (RxD),
    .UART_rd(UART_rd),
    .dout   (dout),
    .RF     (RF),
    .FE     (FE),
    .OE     (OE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] val;
    int          t_lo;
    int          t_hi;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [7:0] m_dout = 8'h00;
  logic       m_rf   = 1'b0;
  logic       m_fe   = 1'b0;
  logic       m_oe   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Record the new model state; an expectation is queued only when the outputs must change.
  task automatic model_set(input logic [7:0] d, input logic rf, input logic fe, input logic oe,
                           input int lo, input int hi, input string nm);
    exp_t e;
    if ({d, rf, fe, oe} != {m_dout, m_rf, m_fe, m_oe}) begin
      e.val  = {d, rf, fe, oe};
      e.t_lo = lo;
      e.t_hi = hi;
      e.name = nm;
      q.push_back(e);
    end
    m_dout = d; m_rf = rf; m_fe = fe; m_oe = oe;
  endtask

  task automatic model_rd(input int t);
    model_set(m_dout, 1'b0, 1'b0, 1'b0, t + 1, t + 1, "read");
  endtask

  task automatic model_reset(input int t);
    model_set(8'h00, 1'b0, 1'b0, 1'b0, t + 1, t + 1, "reset");
  endtask

  // Stop-bit decision lands about 9.5 bit times (152 clk) after the start edge plus synchronizer delay.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic rd, input int t0);
    logic [7:0] d;
    logic       rf, fe, oe;
    d = m_dout; rf = m_rf; fe = m_fe; oe = m_oe;
    if (rd) begin rf = 1'b0; fe = 1'b0; oe = 1'b0; end
    if (stop) begin
      if (m_rf && !rd) oe = 1'b1;
      else begin d = b; rf = 1'b1; end
    end else begin
      fe = 1'b1;
    end
    model_set(d, rf, fe, oe, t0 + 152, t0 + 158, $sformatf("frame_%h", b));
  endtask

  // Drives one 160-clk frame. rd_at: step of a UART_rd pulse (154 = byte-good cycle), -1 none.
  // rst_at: step of a 1-clk reset that abandons the frame, -1 none. Line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at, input int rst_at);
    logic [9:0] bits;
    int         t0;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (rst_at >= 0 && i == rst_at + 1) begin
        resetn  = 1'b1;
        RxD     = 1'b1;
        UART_rd = 1'b0;
        return;
      end
      RxD     = bits[i / 16];
      UART_rd = (i == rd_at);
      if (i == rd_at && rd_at != 154) model_rd(cyc);
      if (i == 150 && rst_at < 0) model_frame(b, stop, rd_at == 154, t0);
      if (i == rst_at) begin
        resetn = 1'b0;
        model_reset(cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      RxD     = 1'b1;
      UART_rd = 1'b0;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      RxD     = 1'b0;
      UART_rd = 1'b0;
    end
  endtask

  task automatic glitch(input int n);
    hold_low(n);
    idle(20);
  endtask

  task automatic rd_pulse();
    @(posedge clk); #1;
    RxD     = 1'b1;
    UART_rd = 1'b1;
    model_rd(cyc);
    @(posedge clk); #1;
    UART_rd = 1'b0;
  endtask

  bit          mon_en = 1'b0;
  logic [10:0] mon_prev;
  logic [10:0] mon_cur;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {dout, RF, FE, OE};
      if (mon_cur !== mon_prev) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_change: got %h, expected no change from %h (cycle %0d)",
                   mon_cur, mon_prev, cyc);
        end else begin
          mon_e = q.pop_front();
          check(mon_e.name, 32'(mon_cur), 32'(mon_e.val));
          vectors++;
          if (cyc < mon_e.t_lo || cyc > mon_e.t_hi) begin
            miscompares++;
            $display("FAIL %s_latency: changed at cycle %0d, expected cycle %0d..%0d",
                     mon_e.name, cyc, mon_e.t_lo, mon_e.t_hi);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    int          rd_at;
    logic [7:0]  b;
    logic        stop;

    resetn  = 1'b0;
    RxD     = 1'b1;
    UART_rd = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_rf",   32'(RF),   32'h0);
    check("reset_fe",   32'(FE),   32'h0);
    check("reset_oe",   32'(OE),   32'h0);
    @(posedge clk); #1;
    resetn   = 1'b1;
    mon_prev = 11'h000;
    mon_en   = 1'b1;
    idle(20);

    // Clean frame, then a read leaves dout intact
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(10);
    check("a5_dout", 32'(dout), 32'hA5);
    rd_pulse();
    idle(5);
    check("a5_after_rd", 32'({dout, RF}), 32'({8'hA5, 1'b0}));

    // Short low glitch is rejected, next frame is clean
    glitch(4);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(10);
    rd_pulse();

    // Bad stop bit, line stuck low must not retrigger
    send_frame(8'h55, 1'b0, -1, -1);
    hold_low(40);
    idle(10);
    check("fe_set", 32'({dout, RF, FE}), 32'({8'h3C, 1'b0, 1'b1}));
    rd_pulse();
    idle(5);

    // Overrun, then a read coinciding with byte-good
    send_frame(8'h11, 1'b1, -1, -1);
    idle(8);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(8);
    check("overrun", 32'({dout, RF, OE}), 32'({8'h11, 1'b1, 1'b1}));
    rd_pulse();
    send_frame(8'h11, 1'b1, -1, -1);
    idle(8);
    send_frame(8'h22, 1'b1, 154, -1);
    idle(8);
    check("rd_wins", 32'({dout, RF, OE}), 32'({8'h22, 1'b1, 1'b0}));
    rd_pulse();

    // Reset in the middle of data bit 4 discards the partial byte
    send_frame(8'hFF, 1'b1, -1, 88);
    idle(20);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(8);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0:       rd_at = 154;
        1:       rd_at = int'($urandom_range(10, 140));
        default: rd_at = -1;
      endcase
      send_frame(b, stop, rd_at, -1);
      idle(int'($urandom_range(4, 20)));
      if ($urandom_range(0, 1) == 1) rd_pulse();
      if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, 7)));
    end

    for (int k = 0; k < 400 && q.size() != 0; k++) @(posedge clk);
    idle(20);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
